bp_be_commit_trace_buffer: RTL and testbench

- Parametrised successor to the BE calculator commit tracer.
- Carries each dispatch packet down a configurable-depth delay line to the commit point and qualifies it with poison, trap and return.
- Stores committed records in an on-chip circular buffer with stop-on-full or wrap mode, arm/trigger capture control and commit/drop counters.
- Drained over a valid/yumi port by a testbench monitor or debug unit.

---
 rtl/bp_be_commit_trace_buffer.sv | 178 +++++++++++++++++
 tb/tb_bp_be_commit_trace_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_commit_trace_buffer.sv
// Commit trace buffer for the BE pipeline.
// Dispatch packets travel down a commit_stage_p-deep delay line to the commit
// point. At commit they are qualified with poison/trap/xRET, and surviving
// records are stored in a circular buffer. Capture is controlled by an
// IDLE/CAPTURE/STOPPED arm/trigger FSM. The buffer is drained through a
// valid/yumi head port.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   freeze_i                  flush the delay line and block capture
//   dispatch_*_i              dispatched packet (valid, pc, instr)
//   commit_poison_i, commit_result_i, trap_v_i, ret_v_i
//                             qualifiers for the commit-stage instruction
//   arm_i, trigger_i          start/resume and stop capture (trigger wins)
//   trace_*_o, trace_yumi_i   head record and consume handshake
//   full_o, empty_o           buffer occupancy
//   capturing_o               FSM is in CAPTURE
//   commit_count_o            records captured (saturating)
//   drop_count_o              records lost, dropped or overwritten (saturating)
module bp_be_commit_trace_buffer #(
    parameter int unsigned vaddr_width_p  = 39,
    parameter int unsigned instr_width_p  = 32,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned commit_stage_p = 3,
    parameter int unsigned els_p          = 16,
    parameter int unsigned wrap_mode_p    = 0,
    parameter int unsigned cnt_width_p    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     freeze_i,
    input  logic                     dispatch_v_i,
    input  logic [vaddr_width_p-1:0] dispatch_pc_i,
    input  logic [instr_width_p-1:0] dispatch_instr_i,
    input  logic                     commit_poison_i,
    input  logic [data_width_p-1:0]  commit_result_i,
    input  logic                     trap_v_i,
    input  logic                     ret_v_i,
    input  logic                     arm_i,
    input  logic                     trigger_i,
    output logic                     trace_v_o,
    output logic [vaddr_width_p-1:0] trace_pc_o,
    output logic [instr_width_p-1:0] trace_instr_o,
    output logic [data_width_p-1:0]  trace_result_o,
    output logic [1:0]               trace_flags_o,
    input  logic                     trace_yumi_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     capturing_o,
    output logic [cnt_width_p-1:0]   commit_count_o,
    output logic [cnt_width_p-1:0]   drop_count_o
);

    localparam int unsigned lg_els_lp = $clog2(els_p);
    localparam int unsigned ptr_w_lp  = lg_els_lp + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, STOPPED} state_e;
    state_e state_r, state_n;

    // Delay line
    logic [commit_stage_p-1:0] dl_v_r;
    logic [vaddr_width_p-1:0]  dl_pc_r    [commit_stage_p];
    logic [instr_width_p-1:0]  dl_instr_r [commit_stage_p];

    always_ff @(posedge clk_i) begin
        if (reset_i || freeze_i) begin
            dl_v_r <= '0;
        end else begin
            dl_v_r[0] <= dispatch_v_i;
            for (int unsigned i = 1; i < commit_stage_p; i++) begin
                dl_v_r[i] <= dl_v_r[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        dl_pc_r[0]    <= dispatch_pc_i;
        dl_instr_r[0] <= dispatch_instr_i;
        for (int unsigned i = 1; i < commit_stage_p; i++) begin
            dl_pc_r[i]    <= dl_pc_r[i-1];
            dl_instr_r[i] <= dl_instr_r[i-1];
        end
    end

    // Commit qualification: a poisoned instruction still produces a record
    // when it takes a trap.
    logic record_v, capture_v;
    assign record_v  = dl_v_r[commit_stage_p-1] & (~commit_poison_i | trap_v_i);
    assign capture_v = record_v & (state_r == CAPTURE) & ~freeze_i;

    // FSM
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        if (trigger_i) begin
            if (state_r == CAPTURE) state_n = STOPPED;
        end else if (arm_i) begin
            state_n = CAPTURE;
        end
    end

    // Circular buffer
    logic [ptr_w_lp-1:0]      wptr_r, rptr_r;
    logic [vaddr_width_p-1:0] mem_pc    [els_p];
    logic [instr_width_p-1:0] mem_instr [els_p];
    logic [data_width_p-1:0]  mem_res   [els_p];
    logic [1:0]               mem_flags [els_p];

    logic empty, full, pop, push, overflow, rd_adv;
    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[lg_els_lp] != rptr_r[lg_els_lp])
                && (wptr_r[lg_els_lp-1:0] == rptr_r[lg_els_lp-1:0]);
    assign pop   = trace_yumi_i & ~empty;
    // Full with no pop: either discard the record or overwrite the head and
    // drag the read pointer along, so occupancy stays at els_p.
    assign overflow = capture_v & full & ~pop;
    assign push     = capture_v & (~overflow | (wrap_mode_p != 0));
    assign rd_adv   = pop | (overflow & (wrap_mode_p != 0));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push)   wptr_r <= wptr_r + ptr_w_lp'(1);
            if (rd_adv) rptr_r <= rptr_r + ptr_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wptr_r[lg_els_lp-1:0]]    <= dl_pc_r[commit_stage_p-1];
            mem_instr[wptr_r[lg_els_lp-1:0]] <= dl_instr_r[commit_stage_p-1];
            mem_res[wptr_r[lg_els_lp-1:0]]   <= commit_result_i;
            mem_flags[wptr_r[lg_els_lp-1:0]] <= {trap_v_i, ret_v_i};
        end
    end

    // Saturating counters
    logic [cnt_width_p-1:0] commit_cnt_r, drop_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            commit_cnt_r <= '0;
            drop_cnt_r   <= '0;
        end else begin
            if (capture_v && commit_cnt_r != '1)
                commit_cnt_r <= commit_cnt_r + cnt_width_p'(1);
            if (overflow && drop_cnt_r != '1)
                drop_cnt_r <= drop_cnt_r + cnt_width_p'(1);
        end
    end

    assign trace_v_o      = ~empty;
    assign trace_pc_o     = mem_pc[rptr_r[lg_els_lp-1:0]];
    assign trace_instr_o  = mem_instr[rptr_r[lg_els_lp-1:0]];
    assign trace_result_o = mem_res[rptr_r[lg_els_lp-1:0]];
    assign trace_flags_o  = mem_flags[rptr_r[lg_els_lp-1:0]];
    assign full_o         = full;
    assign empty_o        = empty;
    assign capturing_o    = (state_r == CAPTURE);
    assign commit_count_o = commit_cnt_r;
    assign drop_count_o   = drop_cnt_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(trace_yumi_i && empty))
                else $error("trace_yumi_i asserted while trace buffer empty");
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_commit_trace_buffer.sv
module tb_bp_be_commit_trace_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, freeze, dv, poison, trap, ret, arm, trigger, yumi;
    logic [38:0] pc;
    logic [31:0] instr;
    logic [63:0] res;

    // drop-mode instance, 3-bit counters so saturation is reachable
    logic        t_v, t_full, t_empty, t_cap;
    logic [38:0] t_pc;
    logic [31:0] t_instr;
    logic [63:0] t_res;
    logic [1:0]  t_flags;
    logic [2:0]  t_cnt, t_drop;

    // wrap-mode instance sharing the same stimulus
    logic        w_v, w_full, w_empty, w_cap;
    logic [38:0] w_pc;
    logic [31:0] w_instr;
    logic [63:0] w_res;
    logic [1:0]  w_flags;
    logic [7:0]  w_cnt, w_drop;

    bp_be_commit_trace_buffer #(
        .commit_stage_p(3), .els_p(4), .wrap_mode_p(0), .cnt_width_p(3)
    ) u_dut (
        .clk_i(clk), .reset_i(reset), .freeze_i(freeze),
        .dispatch_v_i(dv), .dispatch_pc_i(pc), .dispatch_instr_i(instr),
        .commit_poison_i(poison), .commit_result_i(res),
        .trap_v_i(trap), .ret_v_i(ret), .arm_i(arm), .trigger_i(trigger),
        .trace_v_o(t_v), .trace_pc_o(t_pc), .trace_instr_o(t_instr),
        .trace_result_o(t_res), .trace_flags_o(t_flags), .trace_yumi_i(yumi),
        .full_o(t_full), .empty_o(t_empty), .capturing_o(t_cap),
        .commit_count_o(t_cnt), .drop_count_o(t_drop)
    );

    bp_be_commit_trace_buffer #(
        .commit_stage_p(3), .els_p(4), .wrap_mode_p(1), .cnt_width_p(8)
    ) u_wrap (
        .clk_i(clk), .reset_i(reset), .freeze_i(freeze),
        .dispatch_v_i(dv), .dispatch_pc_i(pc), .dispatch_instr_i(instr),
        .commit_poison_i(poison), .commit_result_i(res),
        .trap_v_i(trap), .ret_v_i(ret), .arm_i(arm), .trigger_i(trigger),
        .trace_v_o(w_v), .trace_pc_o(w_pc), .trace_instr_o(w_instr),
        .trace_result_o(w_res), .trace_flags_o(w_flags), .trace_yumi_i(yumi),
        .full_o(w_full), .empty_o(w_empty), .capturing_o(w_cap),
        .commit_count_o(w_cnt), .drop_count_o(w_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [38:0] p);
        logic [31:0] lo;
        lo = p[31:0];
        return lo ^ 32'hA5A5_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        freeze = 0; dv = 0; pc = '0; instr = '0; poison = 0; trap = 0;
        ret = 0; res = '0; arm = 0; trigger = 0; yumi = 0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        step();
        arm = 0;
    endtask

    task automatic disp(input logic [38:0] p);
        dv = 1; pc = p; instr = instr_of(p);
        step();
        dv = 0; pc = '0; instr = '0;
    endtask

    typedef struct {
        logic        dv;
        logic [38:0] pc;
        logic        poison, trap, ret, yumi;
        logic [63:0] res;
        logic        ev;
        logic [38:0] epc;
        logic [1:0]  eflags;
        logic [63:0] eres;
        logic [2:0]  ecnt;
    } vec_t;

    function automatic vec_t mk(input logic d, input logic [38:0] p, input logic po,
                                input logic tr, input logic rt, input logic y,
                                input logic [63:0] r, input logic e, input logic [38:0] ep,
                                input logic [1:0] ef, input logic [63:0] er,
                                input logic [2:0] ec);
        vec_t v;
        v.dv = d; v.pc = p; v.poison = po; v.trap = tr; v.ret = rt; v.yumi = y;
        v.res = r; v.ev = e; v.epc = ep; v.eflags = ef; v.eres = er; v.ecnt = ec;
        return v;
    endfunction

    vec_t tbl[19];

    initial begin
        // row: inputs for one cycle, then outputs expected after that edge
        tbl[0]  = mk(1, 39'h80000000, 0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd0);
        tbl[1]  = mk(1, 39'h80000004, 0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd0);
        tbl[2]  = mk(1, 39'h80000008, 0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd0);
        tbl[3]  = mk(0, 39'h0,        0,0,0,0, 64'h1111, 1, 39'h80000000, 2'b00, 64'h1111, 3'd1);
        tbl[4]  = mk(0, 39'h0,        0,0,0,0, 64'h2222, 1, 39'h80000000, 2'b00, 64'h1111, 3'd2);
        tbl[5]  = mk(0, 39'h0,        0,0,0,0, 64'h3333, 1, 39'h80000000, 2'b00, 64'h1111, 3'd3);
        tbl[6]  = mk(0, 39'h0,        0,0,0,1, 64'h0,    1, 39'h80000004, 2'b00, 64'h2222, 3'd3);
        tbl[7]  = mk(0, 39'h0,        0,0,0,1, 64'h0,    1, 39'h80000008, 2'b00, 64'h3333, 3'd3);
        tbl[8]  = mk(0, 39'h0,        0,0,0,1, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd3);
        tbl[9]  = mk(1, 39'h100,      0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd3);
        tbl[10] = mk(1, 39'h104,      0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd3);
        tbl[11] = mk(0, 39'h0,        0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd3);
        tbl[12] = mk(0, 39'h0,        1,0,0,0, 64'h4444, 0, 39'h0,        2'b00, 64'h0,    3'd3);
        tbl[13] = mk(0, 39'h0,        0,0,1,0, 64'h5555, 1, 39'h104,      2'b01, 64'h5555, 3'd4);
        tbl[14] = mk(1, 39'h200,      0,0,0,1, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd4);
        tbl[15] = mk(0, 39'h0,        0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd4);
        tbl[16] = mk(0, 39'h0,        0,0,0,0, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd4);
        tbl[17] = mk(0, 39'h0,        1,1,0,0, 64'h6666, 1, 39'h200,      2'b10, 64'h6666, 3'd5);
        tbl[18] = mk(0, 39'h0,        0,0,0,1, 64'h0,    0, 39'h0,        2'b00, 64'h0,    3'd5);

        reset = 1;
        idle_in();
        step();
        step();
        reset = 0;

        // reset state
        chk("rst_v",     t_v, 0);
        chk("rst_empty", t_empty, 1);
        chk("rst_full",  t_full, 0);
        chk("rst_cap",   t_cap, 0);
        chk("rst_cnt",   t_cnt, 0);
        chk("rst_drop",  t_drop, 0);

        do_arm();
        chk("arm_cap", t_cap, 1);

        // directed vector table: latency, ordering, poison, trap, ret
        for (int i = 0; i < 19; i++) begin
            dv = tbl[i].dv; pc = tbl[i].pc; instr = tbl[i].dv ? instr_of(tbl[i].pc) : 32'h0;
            poison = tbl[i].poison; trap = tbl[i].trap; ret = tbl[i].ret;
            yumi = tbl[i].yumi; res = tbl[i].res;
            step();
            chk($sformatf("row%0d_v", i),     t_v, tbl[i].ev);
            chk($sformatf("row%0d_empty", i), t_empty, !tbl[i].ev);
            chk($sformatf("row%0d_full", i),  t_full, 0);
            chk($sformatf("row%0d_cnt", i),   t_cnt, tbl[i].ecnt);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_pc", i),    t_pc, tbl[i].epc);
                chk($sformatf("row%0d_instr", i), t_instr, instr_of(tbl[i].epc));
                chk($sformatf("row%0d_res", i),   t_res, tbl[i].eres);
                chk($sformatf("row%0d_flags", i), t_flags, tbl[i].eflags);
            end
        end
        idle_in();

        // overflow: 6 commits into 4 entries without yumi
        do_reset();
        do_arm();
        for (int i = 0; i < 6; i++) disp(39'h1000 + 39'(4 * i));
        repeat (3) step();
        chk("ovf_full",   t_full, 1);
        chk("ovf_head",   t_pc, 39'h1000);
        chk("ovf_drop",   t_drop, 2);
        chk("ovf_cnt",    t_cnt, 6);
        chk("wovf_full",  w_full, 1);
        chk("wovf_head",  w_pc, 39'h1008);
        chk("wovf_drop",  w_drop, 2);
        chk("wovf_cnt",   w_cnt, 6);

        // full with a record and yumi in the same cycle
        disp(39'h2000);
        step();
        step();
        yumi = 1;
        step();
        yumi = 0;
        chk("fy_full",  t_full, 1);
        chk("fy_head",  t_pc, 39'h1004);
        chk("fy_drop",  t_drop, 2);
        chk("fy_cnt",   t_cnt, 7);
        chk("wfy_head", w_pc, 39'h100C);
        chk("wfy_drop", w_drop, 2);

        // counter saturation (3-bit) versus wide counters
        for (int i = 0; i < 6; i++) disp(39'h3000 + 39'(4 * i));
        repeat (3) step();
        chk("sat_cnt",   t_cnt, 3'd7);
        chk("sat_drop",  t_drop, 3'd7);
        chk("sat_head",  t_pc, 39'h1004);
        chk("wsat_cnt",  w_cnt, 13);
        chk("wsat_drop", w_drop, 8);
        chk("wsat_head", w_pc, 39'h3008);

        // trigger during commit #2
        do_reset();
        do_arm();
        disp(39'h4000);
        disp(39'h4004);
        disp(39'h4008);
        step();
        trigger = 1;
        step();
        trigger = 0;
        chk("trg_cap", t_cap, 0);
        step();
        chk("trg_cnt",  t_cnt, 2);
        chk("trg_head", t_pc, 39'h4000);
        arm = 1; yumi = 1;
        disp(39'h400C);
        arm = 0; yumi = 0;
        chk("rearm_cap",  t_cap, 1);
        chk("rearm_head", t_pc, 39'h4004);
        repeat (3) step();
        chk("rearm_cnt", t_cnt, 3);
        yumi = 1;
        step();
        chk("after2_head", t_pc, 39'h400C);
        arm = 1; trigger = 1;
        step();
        arm = 0; trigger = 0; yumi = 0;
        chk("both_cap",   t_cap, 0);
        chk("both_empty", t_empty, 1);

        // freeze with two instructions in flight
        do_reset();
        do_arm();
        disp(39'h5000);
        disp(39'h5004);
        freeze = 1;
        step();
        freeze = 0;
        repeat (4) step();
        chk("frz_empty", t_empty, 1);
        chk("frz_cnt",   t_cnt, 0);
        disp(39'h5008);
        repeat (3) step();
        chk("postfrz_head", t_pc, 39'h5008);
        chk("postfrz_cnt",  t_cnt, 1);

        // reset while draining
        disp(39'h500C);
        repeat (3) step();
        yumi = 1;
        step();
        yumi = 0;
        chk("drain_head", t_pc, 39'h500C);
        reset = 1;
        step();
        reset = 0;
        chk("mrst_v",     t_v, 0);
        chk("mrst_empty", t_empty, 1);
        chk("mrst_cnt",   t_cnt, 0);
        chk("mrst_drop",  t_drop, 0);
        chk("mrst_cap",   t_cap, 0);
        chk("mrst_wv",    w_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
